// File: rtl/factor_sequencer_pkg.sv
// Shared types and constants for the factor display sequencer.
// Mode encodings, FSM state type and width helpers used by the RTL and the bench.
package factor_seq_pkg;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Digit values run 1..num_factors+1, so num_factors+2 distinct codes including 0.
  function automatic int digit_width(input int num_factors);
    return $clog2(num_factors + 2);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int dwell, input int blank);
    return $clog2(max2(dwell, blank) + 1);
  endfunction

endpackage

// File: rtl/factor_sequencer_if.sv
// Bundle between the factorizer-side driver and the display sequencer.
// Signal names keep the factorizer's _i/_o naming as seen from the sequencer.
import factor_seq_pkg::*;

interface factor_sequencer_if #(
  parameter int NUM_FACTORS = 8,
  parameter int DIGIT_W     = digit_width(NUM_FACTORS)
);
  logic [NUM_FACTORS-1:0] factors_i;
  logic                   factors_valid_i;
  logic [1:0]             mode_i;
  logic                   step_i;
  logic [DIGIT_W-1:0]     digit_o;
  logic                   digit_valid_o;
  logic                   wrap_o;

  modport master (
    output factors_i, factors_valid_i, mode_i, step_i,
    input  digit_o, digit_valid_o, wrap_o
  );

  modport slave (
    input  factors_i, factors_valid_i, mode_i, step_i,
    output digit_o, digit_valid_o, wrap_o
  );
endinterface

// File: rtl/factor_sequencer_next_set_bit.sv
// Combinational priority finder: lowest set bit of vec strictly above index from.
// Single-level search, no iteration over clock cycles.
module next_set_bit #(
  parameter int WIDTH = 9,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IDX_W-1:0] from,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning downward lets the lowest qualifying bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i] && (IDX_W'(i) > from)) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/factor_sequencer.sv
// Display sequencer: shows 1 then each factor in the snapshot mask, with dwell/blank timing.
// All outputs registered; digit changes one cycle after restart, step or terminal count.
module factor_sequencer
  import factor_seq_pkg::*;
#(
  parameter int NUM_FACTORS  = 8,
  parameter int DWELL_CYCLES = 10_000_000,
  parameter int BLANK_CYCLES = 0,
  parameter int DIGIT_W      = digit_width(NUM_FACTORS)
) (
  input  logic         clk,
  input  logic         rst_n,
  factor_sequencer_if.slave bus
);

  localparam int VEC_W = NUM_FACTORS + 1;
  localparam int IDX_W = $clog2(VEC_W);
  localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic             HAS_BLANK  = (BLANK_CYCLES > 0);

  state_t                 state;
  logic [NUM_FACTORS-1:0] snap;
  logic [CNT_W-1:0]       cnt;

  logic             is_manual;
  logic             is_freeze;
  logic             restart;
  logic [VEC_W-1:0] search_vec;
  logic [IDX_W-1:0] cur_pos;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_found;
  logic [DIGIT_W-1:0] nxt_digit;

  assign is_manual = (bus.mode_i == MODE_MANUAL);
  assign is_freeze = (bus.mode_i == MODE_FREEZE);
  assign restart   = (state == IDLE) || (bus.factors_i != snap);

  // Position p in search_vec stands for digit p+1; position 0 is the trivial factor 1.
  assign search_vec = {snap, 1'b0};
  assign cur_pos    = IDX_W'(bus.digit_o - 1'b1);

  next_set_bit #(
    .WIDTH (VEC_W),
    .IDX_W (IDX_W)
  ) u_next (
    .vec   (search_vec),
    .from  (cur_pos),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  assign nxt_digit = nxt_found ? (DIGIT_W'(nxt_idx) + 1'b1) : DIGIT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      snap              <= '0;
      cnt               <= '0;
      bus.digit_o       <= '0;
      bus.digit_valid_o <= 1'b0;
      bus.wrap_o        <= 1'b0;
    end else begin
      bus.wrap_o <= 1'b0;
      if (!bus.factors_valid_i) begin
        state             <= IDLE;
        cnt               <= '0;
        bus.digit_o       <= '0;
        bus.digit_valid_o <= 1'b0;
      end else if (is_freeze) begin
        // Hold everything; a mask change seen here becomes a restart once freeze ends.
        state <= state;
      end else if (restart) begin
        snap              <= bus.factors_i;
        state             <= SHOW;
        cnt               <= '0;
        bus.digit_o       <= DIGIT_W'(1);
        bus.digit_valid_o <= 1'b1;
      end else begin
        case (state)
          SHOW: begin
            if (is_manual) begin
              cnt <= '0;
              if (bus.step_i) begin
                bus.digit_o       <= nxt_digit;
                bus.digit_valid_o <= 1'b1;
                bus.wrap_o        <= !nxt_found;
              end
            end else if (cnt == DWELL_LAST) begin
              cnt <= '0;
              if (HAS_BLANK) begin
                state             <= BLANK;
                bus.digit_valid_o <= 1'b0;
              end else begin
                bus.digit_o       <= nxt_digit;
                bus.digit_valid_o <= 1'b1;
                bus.wrap_o        <= !nxt_found;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BLANK: begin
            if (is_manual || (cnt == BLANK_LAST)) begin
              state             <= SHOW;
              cnt               <= '0;
              bus.digit_o       <= nxt_digit;
              bus.digit_valid_o <= 1'b1;
              bus.wrap_o        <= !nxt_found;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_factor_sequencer.sv
// Scoreboard bench for factor_sequencer: expected (digit, valid, wrap) per cycle queued, then compared.
module tb_factor_sequencer;
  import factor_seq_pkg::*;

  localparam int NF    = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int DW    = $clog2(NF + 2);

  typedef struct packed {
    logic [DW-1:0] d;
    logic          v;
    logic          w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  factor_sequencer_if #(.NUM_FACTORS(NF), .DIGIT_W(DW)) bus ();

  factor_sequencer #(
    .NUM_FACTORS  (NF),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [DW-1:0] d, input logic v, input logic w);
    exp_t e;
    e.d = d; e.v = v; e.w = w;
    exp_q.push_back(e);
  endtask

  // One auto-mode digit: DWELL shown cycles (wrap only on the first), then BLANK dark cycles.
  task automatic push_show(input logic [DW-1:0] d, input logic w);
    for (int i = 0; i < DWELL; i++) push(d, 1'b1, (i == 0) ? w : 1'b0);
    for (int i = 0; i < BLANK; i++) push(d, 1'b0, 1'b0);
  endtask

  task automatic go_idle(input string name);
    exp_t e;
    push('0, 1'b0, 1'b0);
    bus.factors_valid_i = 1'b0;
    bus.step_i = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
      errors++;
      $display("FAIL %s_idle: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
               name, bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
    end
  endtask

  task automatic test_reset();
    bus.factors_i = 8'h17; bus.factors_valid_i = 1'b1; bus.mode_i = MODE_AUTO; bus.step_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got d=%0d v=%0b w=%0b, expected all 0", bus.digit_o, bus.digit_valid_o, bus.wrap_o);
    end
    bus.factors_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got d=%0d v=%0b w=%0b, expected all 0", bus.digit_o, bus.digit_valid_o, bus.wrap_o);
    end
  endtask

  task automatic test_auto_composite();
    exp_t e;
    go_idle("auto12");
    bus.mode_i = MODE_AUTO; bus.factors_i = 8'b0001_0111; bus.factors_valid_i = 1'b1;
    push_show(1, 0); push_show(2, 0); push_show(3, 0); push_show(4, 0); push_show(6, 0); push_show(1, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
        errors++;
        $display("FAIL auto12: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
                 bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
      end
    end
  endtask

  task automatic test_auto_prime();
    exp_t e;
    go_idle("prime");
    bus.mode_i = MODE_AUTO; bus.factors_i = 8'h00; bus.factors_valid_i = 1'b1;
    push_show(1, 0); push_show(1, 1); push_show(1, 1); push_show(1, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
        errors++;
        $display("FAIL prime: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
                 bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
      end
    end
  endtask

  task automatic test_manual();
    exp_t e;
    int step_at[4] = '{6, 10, 13, 999};
    logic [DW-1:0] seq[3];
    logic [DW-1:0] exp_d;
    logic w;
    int k;
    // Mask bits 0 and 2 -> factors 2 and 4, so steps visit 2, 4, then wrap to 1.
    seq[0] = 2; seq[1] = 4; seq[2] = 1;
    go_idle("manual");
    bus.mode_i = MODE_MANUAL; bus.factors_i = 8'b0000_0101; bus.factors_valid_i = 1'b1;
    exp_d = 1; k = 0;
    for (int c = 0; c < 18; c++) begin
      bus.step_i = (c == step_at[k]);
      w = 1'b0;
      if (c == step_at[k]) begin
        exp_d = seq[k];
        w = (exp_d == 1);
        k++;
      end
      push(exp_d, 1'b1, w);
      @(posedge clk); #1;
      bus.step_i = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
        errors++;
        $display("FAIL manual c=%0d: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
                 c, bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
      end
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    go_idle("freeze");
    bus.mode_i = MODE_AUTO; bus.factors_i = 8'b0001_0111; bus.factors_valid_i = 1'b1;
    push_show(1, 0); push_show(2, 0); push_show(3, 0); push(4, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) push(4, 1'b1, 1'b0);
    push_show(1, 0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (c == 18) begin bus.mode_i = MODE_FREEZE; bus.factors_i = 8'h01; end
      if (c == 118) bus.mode_i = MODE_AUTO;
      e = exp_q.pop_front();
      checks++;
      if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
        errors++;
        $display("FAIL freeze c=%0d: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
                 c, bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
      end
    end
  endtask

  task automatic test_restart_priority();
    exp_t e;
    go_idle("prio");
    bus.mode_i = MODE_AUTO; bus.factors_i = 8'b0001_0111; bus.factors_valid_i = 1'b1;
    // Mask changes just as the dwell count hits terminal: restart must win over BLANK.
    for (int i = 0; i < DWELL; i++) push(1, 1'b1, 1'b0);
    push_show(1, 0);
    push(2, 1'b1, 1'b0);
    push('0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (c == DWELL - 1) bus.factors_i = 8'h01;
      if (c == 2 * DWELL + BLANK) bus.factors_valid_i = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
        errors++;
        $display("FAIL prio c=%0d: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
                 c, bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    go_idle("arst");
    bus.mode_i = MODE_AUTO; bus.factors_i = 8'b0001_0111; bus.factors_valid_i = 1'b1;
    push_show(1, 0); push_show(2, 0); push(3, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
        errors++;
        $display("FAIL arst_pre: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
                 bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== '0) begin
      errors++;
      $display("FAIL arst_immediate: got d=%0d v=%0b w=%0b, expected all 0", bus.digit_o, bus.digit_valid_o, bus.wrap_o);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    push(1, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({bus.digit_o, bus.digit_valid_o, bus.wrap_o} !== e) begin
      errors++;
      $display("FAIL arst_release: got d=%0d v=%0b w=%0b, expected d=%0d v=%0b w=%0b",
               bus.digit_o, bus.digit_valid_o, bus.wrap_o, e.d, e.v, e.w);
    end
  endtask

  initial begin
    bus.factors_i = '0; bus.factors_valid_i = 1'b0; bus.mode_i = MODE_AUTO; bus.step_i = 1'b0;
    test_reset();
    test_auto_composite();
    test_auto_prime();
    test_manual();
    test_freeze();
    test_restart_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
